// File: rtl/data_mem_arbiter.sv
// ----------------------------------------------------------------------------
// data_mem_arbiter
//
// Shares the single data_memory port between the CPU data port (requester 0)
// and the DMA / test-loader port (requester 1). Only one transaction is in
// flight at a time. Contention is resolved round-robin by default.
//
// Build option:
//   DATA_MEM_ARB_CPU_PRIORITY_EN  - when defined, the CPU always wins
//                                   contention. The DMA port is only served
//                                   in IDLE cycles with no CPU request.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   clk_enable          low: every register holds its value
//   cpu_*               requester 0 (waitrequest / readdatavalid handshake)
//   dma_*               requester 1, same handshake as cpu_*
//   data_address/read/write/writedata   registered strobes to data_memory
//   data_readdata       from data_memory, valid the cycle after data_read
//
// Handshake timing, from a request seen in IDLE at cycle N:
//   N+1  ISSUE : memory strobe high, owner's waitrequest low (acceptance)
//   N+2  RDWAIT: read data passed through to the owner with readdatavalid
// A write occupies the port for 2 cycles and a read for 3 cycles.
// ----------------------------------------------------------------------------
module data_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_enable,

    input  logic [ADDR_WIDTH-1:0] cpu_address,
    input  logic                  cpu_read,
    input  logic                  cpu_write,
    input  logic [DATA_WIDTH-1:0] cpu_writedata,
    output logic                  cpu_waitrequest,
    output logic [DATA_WIDTH-1:0] cpu_readdata,
    output logic                  cpu_readdatavalid,

    input  logic [ADDR_WIDTH-1:0] dma_address,
    input  logic                  dma_read,
    input  logic                  dma_write,
    input  logic [DATA_WIDTH-1:0] dma_writedata,
    output logic                  dma_waitrequest,
    output logic [DATA_WIDTH-1:0] dma_readdata,
    output logic                  dma_readdatavalid,

    output logic [ADDR_WIDTH-1:0] data_address,
    output logic                  data_read,
    output logic                  data_write,
    output logic [DATA_WIDTH-1:0] data_writedata,
    input  logic [DATA_WIDTH-1:0] data_readdata
);

    // state     | meaning
    // ----------+-----------------------------------------------------------
    // ST_IDLE   | strobes low; pick a winner among pending requests
    // ST_ISSUE  | one strobe high with latched values; owner is accepted
    // ST_RDWAIT | strobes low; memory read data passed through to owner
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_RDWAIT = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // owner: 0 = CPU, 1 = DMA
    logic owner;
    logic owner_nxt;

    logic [ADDR_WIDTH-1:0] address_nxt;
    logic [DATA_WIDTH-1:0] writedata_nxt;
    logic                  read_nxt;
    logic                  write_nxt;

    logic cpu_req;
    logic dma_req;
    logic winner;

    logic [ADDR_WIDTH-1:0] win_address;
    logic [DATA_WIDTH-1:0] win_writedata;
    logic                  win_read;
    logic                  win_write;

    logic in_issue;
    logic in_rdwait;

    assign cpu_req   = cpu_read | cpu_write;
    assign dma_req   = dma_read | dma_write;
    assign in_issue  = (state == ST_ISSUE);
    assign in_rdwait = (state == ST_RDWAIT);

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
`ifdef DATA_MEM_ARB_CPU_PRIORITY_EN
    // Fixed priority: the DMA only wins when the CPU is not asking.
    assign winner = ~cpu_req;
`else
    // Round-robin: on contention the requester that did not win last time
    // is granted. last_grant resets to DMA so the CPU wins first contention.
    logic last_grant;

    assign winner = (cpu_req & dma_req) ? ~last_grant : dma_req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (clk_enable) begin
            if ((state == ST_IDLE) && (cpu_req | dma_req)) begin
                last_grant <= winner;
            end
        end
    end
`endif

    // Winner's request; a simultaneous read+write is treated as a write.
    always_comb begin
        win_address   = cpu_address;
        win_writedata = cpu_writedata;
        win_write     = cpu_write;
        win_read      = cpu_read & ~cpu_write;
        if (winner) begin
            win_address   = dma_address;
            win_writedata = dma_writedata;
            win_write     = dma_write;
            win_read      = dma_read & ~dma_write;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and registered memory-side outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        address_nxt   = data_address;
        writedata_nxt = data_writedata;
        read_nxt      = 1'b0;
        write_nxt     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (cpu_req | dma_req) begin
                    owner_nxt     = winner;
                    address_nxt   = win_address;
                    writedata_nxt = win_writedata;
                    read_nxt      = win_read;
                    write_nxt     = win_write;
                    state_nxt     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // The latched op is still visible on the strobe outputs.
                state_nxt = data_write ? ST_IDLE : ST_RDWAIT;
            end
            ST_RDWAIT: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            owner          <= 1'b0;
            data_address   <= '0;
            data_writedata <= '0;
            data_read      <= 1'b0;
            data_write     <= 1'b0;
        end else if (clk_enable) begin
            state          <= state_nxt;
            owner          <= owner_nxt;
            data_address   <= address_nxt;
            data_writedata <= writedata_nxt;
            data_read      <= read_nxt;
            data_write     <= write_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Requester-side outputs (combinational)
    // ------------------------------------------------------------------
    // A request is held off in every cycle except the owner's ISSUE cycle.
    assign cpu_waitrequest = cpu_req & ~(in_issue & ~owner);
    assign dma_waitrequest = dma_req & ~(in_issue &  owner);

    // Read data is steered to the owner only; the other port sees zero.
    assign cpu_readdatavalid = in_rdwait & ~owner;
    assign dma_readdatavalid = in_rdwait &  owner;
    assign cpu_readdata      = cpu_readdatavalid ? data_readdata : '0;
    assign dma_readdata      = dma_readdatavalid ? data_readdata : '0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_data_mem_arbiter
//
// Drives both requester ports, models data_memory, and checks the arbiter
// with a scoreboard. The reference model tracks a shadow memory updated in
// grant order, the expected arbitration decision from the requests present
// in the deciding cycle, and queues of expected read data per requester.
// ----------------------------------------------------------------------------
module tb_data_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          clk_enable;
    logic [AW-1:0] cpu_address, dma_address, data_address;
    logic          cpu_read, cpu_write, dma_read, dma_write;
    logic [DW-1:0] cpu_writedata, dma_writedata;
    logic [DW-1:0] cpu_readdata, dma_readdata, data_writedata;
    logic [DW-1:0] data_readdata = '0;
    logic          cpu_waitrequest, cpu_readdatavalid;
    logic          dma_waitrequest, dma_readdatavalid;
    logic          data_read, data_write;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [16] = '{default: 32'h0};
    logic [31:0] model_mem [16];
    logic [31:0] exp_rd0 [$];
    logic [31:0] exp_rd1 [$];
    bit          grant_log [$];
    bit          last_winner;
    bit   [1:0]  prev_req;
    int          ports_done;

    // monitor scratch
    bit          m_cr, m_dr, m_a0, m_a1, m_w, m_ew, m_wr;
    logic [31:0] m_addr, m_wd, m_exp;

    always #5 clk = ~clk;

    data_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk               (clk),
        .reset             (reset),
        .clk_enable        (clk_enable),
        .cpu_address       (cpu_address),
        .cpu_read          (cpu_read),
        .cpu_write         (cpu_write),
        .cpu_writedata     (cpu_writedata),
        .cpu_waitrequest   (cpu_waitrequest),
        .cpu_readdata      (cpu_readdata),
        .cpu_readdatavalid (cpu_readdatavalid),
        .dma_address       (dma_address),
        .dma_read          (dma_read),
        .dma_write         (dma_write),
        .dma_writedata     (dma_writedata),
        .dma_waitrequest   (dma_waitrequest),
        .dma_readdata      (dma_readdata),
        .dma_readdatavalid (dma_readdatavalid),
        .data_address      (data_address),
        .data_read         (data_read),
        .data_write        (data_write),
        .data_writedata    (data_writedata),
        .data_readdata     (data_readdata)
    );

    // data_memory stand-in: synchronous write, read data one cycle later.
    always @(posedge clk) begin
        if (data_write) mem[data_address[5:2]] <= data_writedata;
        if (data_read)  data_readdata <= mem[data_address[5:2]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int id, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
        if (id == 0) begin
            cpu_read = rd; cpu_write = wr; cpu_address = a; cpu_writedata = d;
        end else begin
            dma_read = rd; dma_write = wr; dma_address = a; dma_writedata = d;
        end
    endtask

    function automatic logic wreq(input int id);
        return (id == 0) ? cpu_waitrequest : dma_waitrequest;
    endfunction

    // Present a request (called just after a rising edge) and hold it until
    // accepted. waits = cycles in which the request was held off.
    task automatic do_txn(input int id, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d,
                          input bit drop, output int waits);
        bit got;
        got   = 0;
        waits = 0;
        drive(id, rd, wr, a, d);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (clk_enable && !wreq(id)) begin
                got = 1;
                break;
            end
            waits++;
        end
        if (!got) chk($sformatf("accept_timeout_port%0d", id), 32'd0, 32'd1);
        @(posedge clk); #1;
        if (drop) drive(id, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic run_port(input int id, input int n);
        int w;
        for (int i = 0; i < n; i++) begin
            int op;
            int gap;
            logic [31:0] a;
            logic [31:0] d;
            op  = $urandom_range(0, 2);
            gap = $urandom_range(0, 2);
            a   = 32'($urandom_range(0, 15)) << 2;
            d   = $urandom;
            do_txn(id, op != 1, op != 0, a, d, gap != 0, w);
            repeat (gap) begin @(posedge clk); #1; end
        end
        drive(id, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic clr_grants();
        grant_log.delete();
    endtask

    initial begin
        int w0, w1;
        bit saw_valid;

        for (int i = 0; i < 16; i++) model_mem[i] = 32'h0;
        reset = 1'b1;
        clk_enable = 1'b1;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        last_winner = 1'b1;
        prev_req    = 2'b00;

        // Scoreboard / monitor
        fork
            forever begin
                @(negedge clk);
                if (reset) begin
                    exp_rd0.delete();
                    exp_rd1.delete();
                    last_winner = 1'b1;
                    prev_req    = 2'b00;
                end else if (clk_enable) begin
                    m_cr = cpu_read | cpu_write;
                    m_dr = dma_read | dma_write;
                    m_a0 = m_cr & !cpu_waitrequest;
                    m_a1 = m_dr & !dma_waitrequest;
                    if (m_a0 && m_a1) begin
                        chk("double_accept", 32'd1, 32'd0);
                    end else if (m_a0 || m_a1) begin
                        m_w = m_a1;
                        if (prev_req == 2'b00) chk("accept_without_request", 32'd1, 32'd0);
`ifdef DATA_MEM_ARB_CPU_PRIORITY_EN
                        m_ew = (prev_req == 2'b11) ? 1'b0 : prev_req[1];
`else
                        m_ew = (prev_req == 2'b11) ? !last_winner : prev_req[1];
`endif
                        chk("grant_owner", {31'd0, m_w}, {31'd0, m_ew});
                        last_winner = m_w;
                        grant_log.push_back(m_w);
                        m_addr = m_w ? dma_address   : cpu_address;
                        m_wd   = m_w ? dma_writedata : cpu_writedata;
                        m_wr   = m_w ? dma_write     : cpu_write;
                        chk("strobe_write", {31'd0, data_write}, {31'd0, m_wr});
                        chk("strobe_read",  {31'd0, data_read},  {31'd0, !m_wr});
                        chk("strobe_address", data_address, m_addr);
                        if (m_wr) begin
                            chk("strobe_writedata", data_writedata, m_wd);
                            model_mem[m_addr[5:2]] = m_wd;
                        end else if (m_w) begin
                            exp_rd1.push_back(model_mem[m_addr[5:2]]);
                        end else begin
                            exp_rd0.push_back(model_mem[m_addr[5:2]]);
                        end
                    end
                    if (!m_cr) chk("cpu_waitrequest_idle", {31'd0, cpu_waitrequest}, 32'd0);
                    if (!m_dr) chk("dma_waitrequest_idle", {31'd0, dma_waitrequest}, 32'd0);
                    if (cpu_readdatavalid && dma_readdatavalid)
                        chk("both_readdatavalid", 32'd1, 32'd0);
                    if (cpu_readdatavalid) begin
                        if (exp_rd0.size() == 0) chk("cpu_unexpected_valid", 32'd1, 32'd0);
                        else begin
                            m_exp = exp_rd0.pop_front();
                            chk("cpu_readdata", cpu_readdata, m_exp);
                        end
                    end else begin
                        chk("cpu_readdata_zero", cpu_readdata, 32'd0);
                    end
                    if (dma_readdatavalid) begin
                        if (exp_rd1.size() == 0) chk("dma_unexpected_valid", 32'd1, 32'd0);
                        else begin
                            m_exp = exp_rd1.pop_front();
                            chk("dma_readdata", dma_readdata, m_exp);
                        end
                    end else begin
                        chk("dma_readdata_zero", dma_readdata, 32'd0);
                    end
                    prev_req = {m_dr, m_cr};
                end
            end
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_data_read",      {31'd0, data_read},  32'd0);
        chk("rst_data_write",     {31'd0, data_write}, 32'd0);
        chk("rst_data_address",   data_address,   32'd0);
        chk("rst_data_writedata", data_writedata, 32'd0);
        chk("rst_waitrequests",   {30'd0, cpu_waitrequest, dma_waitrequest}, 32'd0);
        chk("rst_valids",         {30'd0, cpu_readdatavalid, dma_readdatavalid}, 32'd0);
        @(posedge clk); #1;

        // Simultaneous reads: CPU wins first contention; DMA is held off in
        // the request cycle plus the 3 cycles of the CPU read.
        clr_grants();
        fork
            do_txn(0, 1'b1, 1'b0, 32'h20, 32'd0, 1'b1, w0);
            do_txn(1, 1'b1, 1'b0, 32'h24, 32'd0, 1'b1, w1);
        join
        chk("contend_cpu_waits", w0, 32'd1);
        chk("contend_dma_waits", w1, 32'd4);
        chk("contend_grants", grant_log.size(), 32'd2);
        if (grant_log.size() == 2) begin
            chk("contend_first",  {31'd0, grant_log[0]}, 32'd0);
            chk("contend_second", {31'd0, grant_log[1]}, 32'd1);
        end
        repeat (3) @(posedge clk); #1;

        // Back-to-back contention, 4 writes
        clr_grants();
        fork
            begin
                do_txn(0, 1'b0, 1'b1, 32'h00, 32'hC0C0_0001, 1'b0, w0);
                do_txn(0, 1'b0, 1'b1, 32'h04, 32'hC0C0_0002, 1'b1, w0);
            end
            begin
                do_txn(1, 1'b0, 1'b1, 32'h08, 32'hD0D0_0001, 1'b0, w1);
                do_txn(1, 1'b0, 1'b1, 32'h0C, 32'hD0D0_0002, 1'b1, w1);
            end
        join
        chk("b2b_count", grant_log.size(), 32'd4);
        if (grant_log.size() == 4) begin
`ifdef DATA_MEM_ARB_CPU_PRIORITY_EN
            chk("b2b_g0", {31'd0, grant_log[0]}, 32'd0);
            chk("b2b_g1", {31'd0, grant_log[1]}, 32'd0);
            chk("b2b_g2", {31'd0, grant_log[2]}, 32'd1);
            chk("b2b_g3", {31'd0, grant_log[3]}, 32'd1);
`else
            chk("b2b_g0", {31'd0, grant_log[0]}, 32'd0);
            chk("b2b_g1", {31'd0, grant_log[1]}, 32'd1);
            chk("b2b_g2", {31'd0, grant_log[2]}, 32'd0);
            chk("b2b_g3", {31'd0, grant_log[3]}, 32'd1);
`endif
        end
        repeat (2) @(posedge clk); #1;

        // Solo CPU write then read-back of 0x10
        do_txn(0, 1'b0, 1'b1, 32'h10, 32'h0005_0000, 1'b1, w0);
        chk("wr_waits", w0, 32'd1);
        @(posedge clk); #1;
        do_txn(0, 1'b1, 1'b0, 32'h10, 32'd0, 1'b1, w0);
        chk("rd_waits", w0, 32'd1);
        @(negedge clk);
        chk("rd_valid_n2", {31'd0, cpu_readdatavalid}, 32'd1);
        chk("rd_data_n2",  cpu_readdata, 32'h0005_0000);
        chk("rd_dma_valid_n2", {31'd0, dma_readdatavalid}, 32'd0);
        @(posedge clk); #1;

        // Reset during RDWAIT of a DMA read
        do_txn(1, 1'b1, 1'b0, 32'h10, 32'd0, 1'b1, w1);
        reset = 1'b1;
        @(negedge clk);
        chk("rstmid_dma_valid",  {31'd0, dma_readdatavalid}, 32'd0);
        chk("rstmid_dma_data",   dma_readdata, 32'd0);
        chk("rstmid_strobes",    {30'd0, data_read, data_write}, 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        saw_valid = 0;
        repeat (3) begin
            @(negedge clk);
            if (dma_readdatavalid || cpu_readdatavalid) saw_valid = 1;
        end
        chk("rstmid_no_late_valid", {31'd0, saw_valid}, 32'd0);
        @(posedge clk); #1;
        do_txn(1, 1'b1, 1'b0, 32'h10, 32'd0, 1'b1, w1);
        chk("rstmid_restart_waits", w1, 32'd1);
        repeat (2) @(posedge clk); #1;

        // clk_enable low for 3 cycles while a CPU write is in ISSUE
        drive(0, 1'b0, 1'b1, 32'h18, 32'hABCD_1234);
        @(posedge clk); #1 clk_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ce_hold_write", {31'd0, data_write}, 32'd1);
            chk("ce_hold_wait",  {31'd0, cpu_waitrequest}, 32'd0);
            chk("ce_hold_addr",  data_address, 32'h18);
            @(posedge clk); #1;
        end
        clk_enable = 1'b1;
        @(negedge clk);
        chk("ce_resume_write", {31'd0, data_write}, 32'd1);
        @(posedge clk); #1 drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        chk("ce_done_write", {31'd0, data_write}, 32'd0);
        @(posedge clk); #1;
        do_txn(0, 1'b1, 1'b0, 32'h18, 32'd0, 1'b1, w0);
        repeat (2) @(posedge clk); #1;

        // Randomized traffic on both ports with random clock-enable gaps
        ports_done = 0;
        fork
            begin run_port(0, 30); ports_done++; end
            begin run_port(1, 30); ports_done++; end
            begin
                while (ports_done < 2) begin
                    @(posedge clk); #1;
                    clk_enable = ($urandom_range(0, 3) != 0);
                end
                clk_enable = 1'b1;
            end
        join
        repeat (6) @(posedge clk);
        chk("cpu_reads_drained", exp_rd0.size(), 32'd0);
        chk("dma_reads_drained", exp_rd1.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
